mul_dispatch: RTL and testbench

Operand queue and issue controller that sits directly upstream of `shiftaddmul`. It buffers operand pairs from a valid/ready producer and issues them one at a time to the multiplier through its `inval`/`mulStarted` contract. It captures each `outval`/`mulout` pulse into a result register that a valid/ready consumer drains. The block turns the multi-cycle, non-stallable multiplier into a flow-controlled, in-order stream stage.

---
 rtl/mul_dispatch.sv | 143 ++++++++++++++
 tb/tb_mul_dispatch.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_dispatch.sv
// Operand FIFO plus issue/collect controller in front of the non-stallable shift-add multiplier.
// Operations go out one at a time and in order; each product waits in a result register until the consumer takes it.
module mul_dispatch #(
  parameter int BW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BW-1:0]            s_a,
  input  logic [BW-1:0]            s_b,
  output logic                     m_inval,
  output logic [BW-1:0]            m_inA,
  output logic [BW-1:0]            m_inB,
  input  logic                     m_started,
  input  logic                     m_outval,
  input  logic [2*BW-1:0]          m_mulout,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [2*BW-1:0]          r_prod,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [BW-1:0]     memA [DEPTH];
  logic [BW-1:0]     memB [DEPTH];
  logic              mInval_q;
  logic [BW-1:0]     mInA_q, mInB_q;
  logic              rValid_q;
  logic [2*BW-1:0]   rProd_q;
  logic              err_q;

  logic full;
  logic push;
  logic pop;

  // Ready depends on the stored count only, so a pop in the same cycle cannot open a full FIFO.
  assign full    = (count_q == FULL_COUNT);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign pop     = (state_q == IDLE) && (count_q != '0) && !m_started && !rValid_q;

  assign m_inval = mInval_q;
  assign m_inA   = mInA_q;
  assign m_inB   = mInB_q;
  assign r_valid = rValid_q;
  assign r_prod  = rProd_q;
  assign level   = count_q;
  assign err     = err_q;

  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + COUNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      memA[wrPtr_q] <= s_a;
      memB[wrPtr_q] <= s_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      mInval_q <= 1'b0;
      mInA_q   <= '0;
      mInB_q   <= '0;
      rValid_q <= 1'b0;
      rProd_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      if (rValid_q && r_ready) begin
        rValid_q <= 1'b0;
      end
      // A result pulse outside WAIT has no owner; flag it and otherwise ignore it.
      if (m_outval && (state_q != WAIT)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= ISSUE;
            mInval_q <= 1'b1;
            mInA_q   <= memA[rdPtr_q];
            mInB_q   <= memB[rdPtr_q];
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          mInval_q <= 1'b0;
        end
        WAIT: begin
          if (m_outval) begin
            state_q  <= IDLE;
            rProd_q  <= m_mulout;
            rValid_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mInval_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_dispatch.sv
// Self-checking bench for mul_dispatch: a behavioural multiplier with random latency drives the
// multiplier side, and products are checked in push order against plain a*b arithmetic.
module tb_mul_dispatch;

  localparam int BW    = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [BW-1:0]    s_a = '0;
  logic [BW-1:0]    s_b = '0;
  logic             m_inval;
  logic [BW-1:0]    m_inA, m_inB;
  logic             m_started = 1'b0;
  logic             m_outval = 1'b0;
  logic [2*BW-1:0]  m_mulout = '0;
  logic             r_valid;
  logic             r_ready = 1'b1;
  logic [2*BW-1:0]  r_prod;
  logic [2:0]       level;
  logic             err;

  int total = 0;
  int bad = 0;

  logic            spurReq = 1'b0;
  bit              mdlBusy = 1'b0;
  int              mdlCnt = 0;
  logic [2*BW-1:0] mdlProd = '0;

  int              invalCount = 0;
  int              rvalidCycles = 0;
  int              maxLevel = 0;
  logic [2*BW-1:0] gotQ [$];

  mul_dispatch #(.BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_inval(m_inval), .m_inA(m_inA), .m_inB(m_inB),
    .m_started(m_started), .m_outval(m_outval), .m_mulout(m_mulout),
    .r_valid(r_valid), .r_ready(r_ready), .r_prod(r_prod),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: busy from the issue strobe until a single outval pulse 2..5 cycles later.
  always @(negedge clk) begin
    if (!rstn) begin
      mdlBusy   = 1'b0;
      m_outval  = 1'b0;
      m_started = 1'b0;
    end else begin
      m_outval = spurReq;
      if (spurReq) m_mulout = 8'hA5;
      if (mdlBusy) begin
        if (mdlCnt == 0) begin
          m_outval = 1'b1;
          m_mulout = mdlProd;
          mdlBusy  = 1'b0;
        end else begin
          mdlCnt--;
        end
      end else if (m_inval) begin
        mdlBusy = 1'b1;
        mdlCnt  = $urandom_range(1, 4);
        mdlProd = {{BW{1'b0}}, m_inA} * {{BW{1'b0}}, m_inB};
      end
      m_started = mdlBusy;
    end
  end

  // Observation only: records strobes and every product handed to the consumer.
  always @(negedge clk) begin
    if (m_inval) invalCount++;
    if (r_valid) rvalidCycles++;
    if (r_valid && r_ready) gotQ.push_back(r_prod);
    if (int'(level) > maxLevel) maxLevel = int'(level);
  end

  function automatic logic [2*BW-1:0] prodOf(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
  endfunction

  task automatic pushPair(input logic [BW-1:0] a, input logic [BW-1:0] b, output bit ok);
    ok = 1'b0;
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic waitResults(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (gotQ.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
    total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    total++; if (m_inval !== 1'b0 || r_valid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got inval=%b rvalid=%b err=%b expected 0 0 0", m_inval, r_valid, err);
    end
    total++; if (m_inA !== 4'd0 || m_inB !== 4'd0 || r_prod !== 8'd0) begin
      bad++; $display("[TB] FAIL reset_data: got inA=%0h inB=%0h prod=%0h expected 0 0 0", m_inA, m_inB, r_prod);
    end
  endtask

  task automatic test_single;
    int baseG, baseI, baseR;
    bit ok;
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    baseG = gotQ.size();
    baseI = invalCount;
    baseR = rvalidCycles;
    s_a = 4'd3;
    s_b = 4'd5;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    total++; if (m_inval !== 1'b0) begin bad++; $display("[TB] FAIL single_early_inval: got %b expected 0", m_inval); end
    @(negedge clk);
    total++; if (m_inval !== 1'b1) begin bad++; $display("[TB] FAIL single_inval: got %b expected 1", m_inval); end
    total++; if (m_inA !== 4'd3 || m_inB !== 4'd5) begin
      bad++; $display("[TB] FAIL single_operands: got %0d,%0d expected 3,5", m_inA, m_inB);
    end
    @(negedge clk);
    total++; if (m_inval !== 1'b0) begin bad++; $display("[TB] FAIL single_inval_width: got %b expected 0", m_inval); end
    waitResults(baseG + 1, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL single_timeout: got %0d results expected 1", gotQ.size() - baseG); end
    else begin
      total++; if (gotQ[baseG] !== 8'h0F) begin bad++; $display("[TB] FAIL single_prod: got %0h expected 0f", gotQ[baseG]); end
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (invalCount - baseI != 1) begin bad++; $display("[TB] FAIL single_issue_count: got %0d expected 1", invalCount - baseI); end
    total++; if (rvalidCycles - baseR != 1) begin bad++; $display("[TB] FAIL single_rvalid_cycles: got %0d expected 1", rvalidCycles - baseR); end
  endtask

  task automatic test_boundary;
    logic [BW-1:0]   aList [3];
    logic [BW-1:0]   bList [3];
    logic [2*BW-1:0] expList [3];
    int baseG;
    bit ok;
    aList = '{4'd15, 4'd0, 4'd1};
    bList = '{4'd15, 4'd9, 4'd1};
    expList = '{8'hE1, 8'h00, 8'h01};
    @(posedge clk);
    #1;
    baseG = gotQ.size();
    for (int i = 0; i < 3; i++) begin
      pushPair(aList[i], bList[i], ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL boundary_push%0d: got not accepted expected accepted", i); end
    end
    waitResults(baseG + 3, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL boundary_timeout: got %0d results expected 3", gotQ.size() - baseG); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (gotQ[baseG+i] !== expList[i]) begin
          bad++; $display("[TB] FAIL boundary_prod%0d: got %0h expected %0h", i, gotQ[baseG+i], expList[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [BW-1:0]   a, b;
    logic [2*BW-1:0] expList [$];
    bit accepted [6];
    int baseG, baseI;
    bit ok;
    bit moved;
    repeat (2) @(posedge clk);
    #1;
    r_ready = 1'b0;
    baseG = gotQ.size();
    baseI = invalCount;
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      s_a = a;
      s_b = b;
      s_valid = 1'b1;
      @(negedge clk);
      accepted[i] = s_ready;
      if (i < 5) expList.push_back(prodOf(a, b));
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (accepted[i] !== (i < 5)) begin
        bad++; $display("[TB] FAIL bp_accept%0d: got %b expected %b", i, accepted[i], (i < 5));
      end
    end
    repeat (15) @(posedge clk);
    @(negedge clk);
    total++; if (invalCount - baseI != 1) begin bad++; $display("[TB] FAIL bp_issue_count: got %0d expected 1", invalCount - baseI); end
    total++; if (r_valid !== 1'b1 || r_prod !== expList[0]) begin
      bad++; $display("[TB] FAIL bp_held: got valid=%b prod=%0h expected 1 %0h", r_valid, r_prod, expList[0]);
    end
    total++; if (level !== 3'd4 || s_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_full: got level=%0d ready=%b expected 4 0", level, s_ready);
    end
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level != 3'd4) begin
        moved = 1'b1;
        break;
      end
    end
    total++; if (!moved || level !== 3'd3 || s_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_first_pop: got level=%0d ready=%b expected 3 1", level, s_ready);
    end
    waitResults(baseG + 5, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL bp_timeout: got %0d results expected 5", gotQ.size() - baseG); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (gotQ[baseG+i] !== expList[i]) begin
          bad++; $display("[TB] FAIL bp_order%0d: got %0h expected %0h", i, gotQ[baseG+i], expList[i]);
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [BW-1:0]   a [4];
    logic [BW-1:0]   b [4];
    int baseG;
    bit ok;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      a[i] = 4'($urandom);
      b[i] = 4'($urandom);
    end
    r_ready = 1'b0;
    baseG = gotQ.size();
    pushPair(a[0], b[0], ok);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL simul_first_result: got no r_valid expected r_valid"); end
    @(posedge clk);
    #1;
    pushPair(a[1], b[1], ok);
    pushPair(a[2], b[2], ok);
    @(negedge clk);
    total++; if (level !== 3'd2) begin bad++; $display("[TB] FAIL simul_level_before: got %0d expected 2", level); end
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    s_a = a[3];
    s_b = b[3];
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    total++; if (level !== 3'd2 || m_inval !== 1'b1) begin
      bad++; $display("[TB] FAIL simul_level: got level=%0d inval=%b expected 2 1", level, m_inval);
    end
    total++; if (m_inA !== a[1] || m_inB !== b[1]) begin
      bad++; $display("[TB] FAIL simul_head: got %0d,%0d expected %0d,%0d", m_inA, m_inB, a[1], b[1]);
    end
    waitResults(baseG + 4, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL simul_timeout: got %0d results expected 4", gotQ.size() - baseG); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (gotQ[baseG+i] !== prodOf(a[i], b[i])) begin
          bad++; $display("[TB] FAIL simul_order%0d: got %0h expected %0h", i, gotQ[baseG+i], prodOf(a[i], b[i]));
        end
      end
    end
  endtask

  task automatic test_reset_wait;
    int baseG, baseR;
    bit ok;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    r_ready = 1'b1;
    pushPair(4'd9, 4'd4, ok);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_inval) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL rstwait_issue: got no m_inval expected m_inval"); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    total++; if (m_inval !== 1'b0 || r_valid !== 1'b0 || err !== 1'b0 || m_inA !== 4'd0 || m_inB !== 4'd0 || r_prod !== 8'd0) begin
      bad++; $display("[TB] FAIL rstwait_outputs: got inval=%b rvalid=%b err=%b inA=%0h inB=%0h prod=%0h expected all 0",
                      m_inval, r_valid, err, m_inA, m_inB, r_prod);
    end
    total++; if (level !== 3'd0 || s_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rstwait_fifo: got level=%0d ready=%b expected 0 1", level, s_ready);
    end
    baseR = rvalidCycles;
    repeat (12) @(negedge clk);
    total++; if (rvalidCycles != baseR) begin bad++; $display("[TB] FAIL rstwait_stale: got %0d r_valid cycles expected 0", rvalidCycles - baseR); end
    @(posedge clk);
    #1;
    baseG = gotQ.size();
    pushPair(4'd2, 4'd7, ok);
    waitResults(baseG + 1, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rstwait_timeout: got 0 results expected 1"); end
    else begin
      total++; if (gotQ[baseG] !== 8'h0E) begin bad++; $display("[TB] FAIL rstwait_prod: got %0h expected 0e", gotQ[baseG]); end
    end
  endtask

  task automatic test_spurious;
    int baseG, baseR;
    repeat (3) @(posedge clk);
    #1;
    baseG = gotQ.size();
    baseR = rvalidCycles;
    spurReq = 1'b1;
    @(posedge clk);
    #1;
    spurReq = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL spur_err: got %b expected 1", err); end
    total++; if (r_valid !== 1'b0 || r_prod !== 8'h0E || m_inval !== 1'b0) begin
      bad++; $display("[TB] FAIL spur_ignored: got rvalid=%b prod=%0h inval=%b expected 0 0e 0", r_valid, r_prod, m_inval);
    end
    repeat (10) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL spur_sticky: got %b expected 1", err); end
    total++; if (rvalidCycles != baseR || gotQ.size() != baseG) begin
      bad++; $display("[TB] FAIL spur_capture: got %0d r_valid cycles expected 0", rvalidCycles - baseR);
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL spur_reset_clear: got %b expected 0", err); end
  endtask

  task automatic test_random;
    localparam int N = 20;
    logic [2*BW-1:0] expQ [$];
    int baseG;
    int pushFails;
    logic [BW-1:0] a, b;
    bit ok;
    @(posedge clk);
    #1;
    baseG = gotQ.size();
    pushFails = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          a = 4'($urandom);
          b = 4'($urandom);
          expQ.push_back(prodOf(a, b));
          pushPair(a, b, ok);
          if (!ok) pushFails++;
        end
      end
      begin
        for (int c = 0; c < 4000; c++) begin
          @(posedge clk);
          #1;
          r_ready = 1'($urandom_range(0, 1));
          if (gotQ.size() >= baseG + N) break;
        end
      end
    join
    r_ready = 1'b1;
    total++; if (pushFails != 0) begin bad++; $display("[TB] FAIL rand_push: got %0d stalled pushes expected 0", pushFails); end
    total++; if (gotQ.size() != baseG + N) begin
      bad++; $display("[TB] FAIL rand_count: got %0d results expected %0d", gotQ.size() - baseG, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++; if (gotQ[baseG+i] !== expQ[i]) begin
          bad++; $display("[TB] FAIL rand_order%0d: got %0h expected %0h", i, gotQ[baseG+i], expQ[i]);
        end
      end
    end
    total++; if (maxLevel > DEPTH) begin bad++; $display("[TB] FAIL rand_max_level: got %0d expected <= %0d", maxLevel, DEPTH); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rand_err: got %b expected 0", err); end
  endtask

  initial begin
    $display("[TB] starting mul_dispatch bench");
    test_reset;
    test_single;
    test_boundary;
    test_backpressure;
    test_simultaneous;
    test_reset_wait;
    test_spurious;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
